// File: rtl/glitch_pkg.sv
// Shared types for the glitch checker datapath.
//   tx_state_t  : TX serialiser states.
//   fault_rec_t : one queued fault record (observed byte, XOR syndrome).
//   make_rec    : builds a record from the observed and expected bytes.
package glitch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND_OBS,
        SEND_SYN
    } tx_state_t;

    typedef struct packed {
        logic [7:0] obs;
        logic [7:0] syn;
    } fault_rec_t;

    function automatic fault_rec_t make_rec(input logic [7:0] obs, input logic [7:0] exp_b);
        fault_rec_t r;
        r.obs = obs;
        r.syn = obs ^ exp_b;
        return r;
    endfunction

endpackage

// File: rtl/fault_fifo.sv
// Synchronous FIFO holding fault records for the glitch checker.
// DEPTH must be a power of 2 and at least 2; pointers wrap naturally.
// Ports:
//   glitched_clk : clock
//   rst          : synchronous active-low reset (clears storage, pointers, occupancy)
//   push_i       : write wr_data_i; ignored when full (full is the pre-edge occupancy)
//   pop_i        : advance read pointer; ignored when empty
//   flush_i      : discard all entries; wins over push and pop
//   wr_data_i    : element to write
//   rd_data_o    : head element (valid when not empty)
//   full_o       : occupancy equals DEPTH
//   empty_o      : occupancy is zero
module fault_fifo
    import glitch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type elem_t = fault_rec_t
) (
    input  logic  glitched_clk,
    input  logic  rst,
    input  logic  push_i,
    input  logic  pop_i,
    input  logic  flush_i,
    input  elem_t wr_data_i,
    output elem_t rd_data_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    elem_t          mem_q [DEPTH];
    elem_t          mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign rd_data_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge glitched_clk) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/glitch_checker.sv
// Checks the byte stream leaving the glitched pipeline against a regenerated
// incrementing pattern, counts faults, and serialises a two-byte record
// (observed byte, XOR syndrome) per fault to the UART transmitter.
// Ports:
//   glitched_clk : clock
//   rst          : synchronous active-low reset
//   DV_2, sum    : upstream byte and its valid
//   seed_load    : restart strobe; seed is the first expected byte of the run
//   tx_data      : registered byte to UART TX
//   tx_valid     : registered valid, held until accepted
//   tx_ready     : UART TX accepts tx_data this cycle
//   err_count    : saturating fault count since reset or seed load
//   overflow     : sticky, a fault record was dropped on a full FIFO
module glitch_checker
    import glitch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             glitched_clk,
    input  logic             rst,
    input  logic             DV_2,
    input  logic [7:0]       sum,
    input  logic             seed_load,
    input  logic [7:0]       seed,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [CNT_W-1:0] err_count,
    output logic             overflow
);

    logic [7:0]       exp_q, exp_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             overflow_q, overflow_d;

    tx_state_t        state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       syn_q, syn_d;

    logic             fault;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    fault_rec_t       fifo_wr, fifo_rd;

    // seed_load wins over DV_2, so a byte in a seed cycle is never a fault.
    assign fault     = DV_2 && !seed_load && (sum != exp_q);
    assign fifo_push = fault && !fifo_full;
    assign fifo_wr   = make_rec(sum, exp_q);

    always_comb begin
        exp_d       = exp_q;
        err_count_d = err_count_q;
        overflow_d  = overflow_q;
        if (seed_load) begin
            exp_d       = seed;
            err_count_d = '0;
            overflow_d  = 1'b0;
        end else if (DV_2) begin
            exp_d = exp_q + 8'd1;
            if (fault) begin
                if (err_count_q != {CNT_W{1'b1}}) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
                if (fifo_full) begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    fault_fifo #(
        .DEPTH  (DEPTH),
        .elem_t (fault_rec_t)
    ) u_fifo (
        .glitched_clk (glitched_clk),
        .rst          (rst),
        .push_i       (fifo_push),
        .pop_i        (fifo_pop),
        .flush_i      (seed_load),
        .wr_data_i    (fifo_wr),
        .rd_data_o    (fifo_rd),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // The syndrome is parked in syn_q at pop time so the FIFO slot is free
    // while the observed byte is still waiting for its handshake.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        syn_d      = syn_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_data_d  = fifo_rd.obs;
                    syn_d      = fifo_rd.syn;
                    tx_valid_d = 1'b1;
                    state_d    = SEND_OBS;
                end
            end
            SEND_OBS: begin
                if (tx_valid_q && tx_ready) begin
                    tx_data_d = syn_q;
                    state_d   = SEND_SYN;
                end
            end
            SEND_SYN: begin
                if (tx_valid_q && tx_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        tx_data_d = fifo_rd.obs;
                        syn_d     = fifo_rd.syn;
                        state_d   = SEND_OBS;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge glitched_clk) begin
        if (!rst) begin
            exp_q       <= '0;
            err_count_q <= '0;
            overflow_q  <= 1'b0;
            state_q     <= IDLE;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            syn_q       <= '0;
        end else begin
            exp_q       <= exp_d;
            err_count_q <= err_count_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            syn_q       <= syn_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign err_count = err_count_q;
    assign overflow  = overflow_q;

endmodule
